// File: rtl/bit_serial_datapath.sv
// Bit-serial datapath: accumulator A and rotating operand B feed a one-bit ALU
// with a carry flip-flop; write publishes the finished word and its flags.
module bit_serial_datapath #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             write,
  input  logic [2:0]       alu_func,
  input  logic             load,
  input  logic             load_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic [CW-1:0]    bit_idx
);

  typedef enum logic [2:0] {
    F_PASS = 3'b000,
    F_ADD  = 3'b001,
    F_SUB  = 3'b010,
    F_AND  = 3'b011,
    F_OR   = 3'b100,
    F_XOR  = 3'b101,
    F_MOVB = 3'b110,
    F_RSVD = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  alu_op_e op;
  logic    a_bit;
  logic    b_bit;
  logic    b_eff;
  logic    cin;
  logic    r_bit;
  logic    cout;

  always_comb begin
    op    = alu_op_e'(alu_func);
    a_bit = a_q[0];
    b_bit = b_q[0];
    b_eff = (op == F_SUB) ? ~b_bit : b_bit;
    // Bit 0 seeds the carry: 1 for subtract (two's complement), 0 otherwise.
    cin   = (bit_idx == '0) ? (op == F_SUB) : carry_q;
    r_bit = a_bit;
    cout  = 1'b0;
    unique case (op)
      F_ADD, F_SUB: begin
        r_bit = a_bit ^ b_eff ^ cin;
        cout  = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);
      end
      F_AND:   r_bit = a_bit & b_bit;
      F_OR:    r_bit = a_bit | b_bit;
      F_XOR:   r_bit = a_bit ^ b_bit;
      F_MOVB:  r_bit = b_bit;
      default: r_bit = a_bit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      bit_idx    <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      if (write) begin
        result     <= a_q;
        carry_flag <= carry_q;
        zero_flag  <= (a_q == '0);
      end
      // Load wins over shift; the whole shift step is dropped that cycle.
      if (load) begin
        if (load_sel) b_q <= din;
        else          a_q <= din;
      end else if (shift) begin
        a_q     <= {r_bit, a_q[WIDTH-1:1]};
        b_q     <= {b_q[0], b_q[WIDTH-1:1]};
        carry_q <= cout;
        bit_idx <= (bit_idx == CW'(WIDTH - 1)) ? '0 : bit_idx + 1'b1;
      end
    end
  end

endmodule
